seg_scan_scheduler: RTL and testbench

SEG_SCAN_SCHEDULER -- requirements
Module: seg_scan_scheduler

---
 rtl/seg_scan_scheduler.sv | 175 +++++++++++++++++
 tb/tb_seg_scan_scheduler.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_scheduler.sv
// Eight-digit multiplexed 7-segment scan controller with blanking gaps between
// digits, a double-buffered digit store and optional leading-zero suppression.
module seg_scan_scheduler #(
    parameter int unsigned DIV       = 1000,
    parameter int unsigned BLANK_CYC = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [3:0] wr_data,
    input  logic       wr_dp,
    input  logic       update,
    input  logic       blank_lz,
    output logic [2:0] count,
    output logic [7:0] com,
    output logic [7:0] seg,
    output logic       frame_done,
    output logic       upd_pending
);

    typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;

    localparam logic [15:0] DIV_LAST   = 16'(DIV - 1);
    localparam logic [15:0] BLANK_LAST = 16'(BLANK_CYC - 1);

    state_t          state_q, state_d;
    logic [15:0]     tmr_q, tmr_d;
    logic [2:0]      count_q, count_d;
    logic [7:0]      com_q, com_d;
    logic [7:0]      seg_q, seg_d;
    logic            fd_q, fd_d;
    logic            pend_q, pend_d;
    logic [7:0][3:0] sh_val_q, act_val_q, act_val_d;
    logic [7:0]      sh_dp_q, act_dp_q, act_dp_d;
    logic            commit;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    // A digit is suppressed only while every digit to its left (and itself) is a bare zero.
    function automatic logic [7:0] digit_seg(input logic [2:0] idx, input logic [7:0][3:0] vals,
                                             input logic [7:0] dps, input logic lz);
        logic [7:0] nz;
        logic [7:0] upto;
        for (int k = 0; k < 8; k++) begin
            nz[k] = (vals[k] != 4'd0) || dps[k];
        end
        upto = 8'hFF >> (3'd7 - idx);
        if (lz && (idx != 3'd7) && ((nz & upto) == 8'd0)) begin
            digit_seg = 8'h00;
        end else begin
            digit_seg = {dps[idx], hex7(vals[idx])};
        end
    endfunction

    function automatic logic [7:0] com_for(input logic [2:0] idx);
        com_for = 8'hFF;
        com_for[3'd7 - idx] = 1'b0;
    endfunction

    always_comb begin
        commit    = pend_q && (fd_q || (state_q == IDLE));
        act_val_d = commit ? sh_val_q : act_val_q;
        act_dp_d  = commit ? sh_dp_q : act_dp_q;
        pend_d    = update ? 1'b1 : (commit ? 1'b0 : pend_q);

        state_d = state_q;
        tmr_d   = tmr_q;
        count_d = count_q;
        com_d   = 8'hFF;
        seg_d   = 8'h00;

        case (state_q)
            IDLE: begin
                tmr_d   = 16'd0;
                count_d = 3'd0;
                if (enable) state_d = SHOW;
            end
            SHOW: begin
                if (!enable) begin
                    state_d = IDLE;
                    tmr_d   = 16'd0;
                    count_d = 3'd0;
                end else if (tmr_q == DIV_LAST) begin
                    state_d = BLANK;
                    tmr_d   = 16'd0;
                end else begin
                    tmr_d = tmr_q + 16'd1;
                end
            end
            BLANK: begin
                if (!enable) begin
                    state_d = IDLE;
                    tmr_d   = 16'd0;
                    count_d = 3'd0;
                end else if (tmr_q == BLANK_LAST) begin
                    state_d = SHOW;
                    tmr_d   = 16'd0;
                    count_d = count_q + 3'd1;
                end else begin
                    tmr_d = tmr_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
                tmr_d   = 16'd0;
                count_d = 3'd0;
            end
        endcase

        // Outputs are registered, so encode from the post-commit buffer for the upcoming cycle.
        if (state_d == SHOW) begin
            com_d = com_for(count_d);
            seg_d = digit_seg(count_d, act_val_d, act_dp_d, blank_lz);
        end
        fd_d = (state_d == BLANK) && (tmr_d == BLANK_LAST) && (count_d == 3'd7);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            tmr_q     <= 16'd0;
            count_q   <= 3'd0;
            com_q     <= 8'hFF;
            seg_q     <= 8'h00;
            fd_q      <= 1'b0;
            pend_q    <= 1'b0;
            sh_val_q  <= '0;
            sh_dp_q   <= 8'h00;
            act_val_q <= '0;
            act_dp_q  <= 8'h00;
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            count_q   <= count_d;
            com_q     <= com_d;
            seg_q     <= seg_d;
            fd_q      <= fd_d;
            pend_q    <= pend_d;
            act_val_q <= act_val_d;
            act_dp_q  <= act_dp_d;
            if (wr_en) begin
                sh_val_q[wr_addr] <= wr_data;
                sh_dp_q[wr_addr]  <= wr_dp;
            end
        end
    end

    assign count       = count_q;
    assign com         = com_q;
    assign seg         = seg_q;
    assign frame_done  = fd_q;
    assign upd_pending = pend_q;

endmodule

// File: tb/tb_seg_scan_scheduler.sv
// Directed bench for seg_scan_scheduler with DIV=4, BLANK_CYC=1 (40-cycle frames).
module tb_seg_scan_scheduler;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [3:0] wr_data;
    logic       wr_dp;
    logic       update;
    logic       blank_lz;
    logic [2:0] count;
    logic [7:0] com;
    logic [7:0] seg;
    logic       frame_done;
    logic       upd_pending;

    int n_cmp = 0;
    int n_err = 0;

    seg_scan_scheduler #(.DIV(4), .BLANK_CYC(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_dp      (wr_dp),
        .update     (update),
        .blank_lz   (blank_lz),
        .count      (count),
        .com        (com),
        .seg        (seg),
        .frame_done (frame_done),
        .upd_pending(upd_pending)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One full frame: checks every cycle, then drives the scenario's stimulus for that cycle.
    task automatic run_frame(input logic [7:0] exp_seg [8], input logic pend0, input int stim);
        logic [7:0] wz [8];
        wz = '{8'd0, 8'd0, 8'd0, 8'd5, 8'd0, 8'd0, 8'd0, 8'd0};
        for (int c = 0; c < 40; c++) begin
            int         slot;
            logic       show;
            logic [7:0] ecom;
            logic [7:0] eseg;
            slot = c / 5;
            show = (c % 5) != 4;
            ecom = show ? ~(8'h80 >> slot) : 8'hFF;
            eseg = show ? exp_seg[slot] : 8'h00;
            @(negedge clk);
            check_eq("com", com, ecom);
            check_eq("seg", seg, eseg);
            check_eq("count", count, slot);
            check_eq("frame_done", frame_done, c == 39);
            if (c == 0) check_eq("pend_frame_start", upd_pending, pend0);
            wr_en  = 1'b0;
            update = 1'b0;
            case (stim)
                1: begin
                    if (c < 8) begin
                        wr_en = 1'b1; wr_addr = 3'(c); wr_data = 4'(c + 1); wr_dp = (c == 7);
                    end
                    if (c == 10) update = 1'b1;
                    if (c == 11) check_eq("pend_after_update", upd_pending, 1);
                    if (c == 39) check_eq("pend_at_frame_done", upd_pending, 1);
                end
                2: begin
                    if (c == 5) update = 1'b1;
                    if (c == 39) begin
                        update = 1'b1;
                        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 4'd9; wr_dp = 1'b0;
                    end
                end
                3: begin
                    if (c < 8) begin
                        wr_en = 1'b1; wr_addr = 3'(c); wr_data = wz[c][3:0]; wr_dp = 1'b0;
                    end
                    if (c == 10) update = 1'b1;
                    if (c == 39) blank_lz = 1'b1;
                end
                4: begin
                    if (c == 0) begin
                        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 4'd0; wr_dp = 1'b0;
                    end
                    if (c == 10) update = 1'b1;
                end
                default: ;
            endcase
        end
    endtask

    initial begin
        logic [7:0] e [8];
        logic       found;

        rst_n = 1'b0; enable = 1'b0; wr_en = 1'b0; wr_addr = 3'd0; wr_data = 4'd0;
        wr_dp = 1'b0; update = 1'b0; blank_lz = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_com", com, 8'hFF);
        check_eq("rst_seg", seg, 8'h00);
        check_eq("rst_count", count, 0);
        check_eq("rst_frame_done", frame_done, 0);
        check_eq("rst_pend", upd_pending, 0);
        rst_n = 1'b1;
        @(negedge clk);
        enable = 1'b1;

        e = '{8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F};
        run_frame(e, 1'b0, 1);
        e = '{8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'hFF};
        run_frame(e, 1'b0, 2);
        run_frame(e, 1'b1, 0);
        e = '{8'h06, 8'h5B, 8'h4F, 8'h6F, 8'h6D, 8'h7D, 8'h07, 8'hFF};
        run_frame(e, 1'b0, 3);
        e = '{8'h00, 8'h00, 8'h00, 8'h6D, 8'h3F, 8'h3F, 8'h3F, 8'h3F};
        run_frame(e, 1'b0, 4);
        e = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h3F};
        run_frame(e, 1'b0, 0);

        // Disable during the SHOW of digit 5
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (count == 3'd5 && com == 8'hFB) found = 1'b1;
        end
        check_eq("reach_digit5", found, 1);
        enable = 1'b0;
        blank_lz = 1'b0;
        @(negedge clk);
        check_eq("dis_com", com, 8'hFF);
        check_eq("dis_count", count, 0);
        check_eq("dis_seg", seg, 8'h00);
        check_eq("dis_frame_done", frame_done, 0);
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 4'hA; wr_dp = 1'b0;
        @(negedge clk);
        wr_en = 1'b0; update = 1'b1;
        @(negedge clk);
        update = 1'b0;
        check_eq("idle_pend_set", upd_pending, 1);
        @(negedge clk);
        check_eq("idle_pend_commit", upd_pending, 0);
        check_eq("idle_com", com, 8'hFF);
        enable = 1'b1;
        @(negedge clk);
        check_eq("reen_com", com, 8'h7F);
        check_eq("reen_count", count, 0);
        check_eq("reen_seg", seg, 8'h77);

        // Reset in the middle of BLANK with a commit outstanding
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
        check_eq("pre_rst_pend", upd_pending, 1);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (com == 8'hFF) found = 1'b1;
        end
        check_eq("reach_blank", found, 1);
        #1 rst_n = 1'b0;
        #1;
        check_eq("arst_com", com, 8'hFF);
        check_eq("arst_pend", upd_pending, 0);
        check_eq("arst_count", count, 0);
        check_eq("arst_seg", seg, 8'h00);
        enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
        @(negedge clk);
        check_eq("post_rst_pend", upd_pending, 0);
        enable = 1'b1;
        @(negedge clk);
        check_eq("post_rst_com", com, 8'h7F);
        check_eq("post_rst_seg", seg, 8'h3F);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
